// File: rtl/df_process_profiler_if.sv
// ----------------------------------------------------------------------------
// df_process_profiler_if
// Bundles the monitored ap_ctrl_chain handshake, FIFO stall indicators,
// control inputs and profiler results into one connection point.
//
//   master : the side driving the monitored handshake (process / testbench)
//   slave  : the profiler
//
// Signals
//   clear, finish                  control (master -> slave)
//   ap_start/ap_ready/ap_done/ap_continue, pin_stall, pout_stall
//                                  monitored process signals (master -> slave)
//   lat_ready                      latency record consumer ready (master -> slave)
//   *_cycles, txn_count            saturating counters (slave -> master)
//   lat_valid, lat_data            latency record stream head (slave -> master)
//   lat_overflow                   sticky record-dropped flag (slave -> master)
//   state                          profiler FSM state (slave -> master)
// ----------------------------------------------------------------------------
interface df_process_profiler_if #(
    parameter int CNT_W = 32
);
    logic             clear;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             pin_stall;
    logic             pout_stall;
    logic             finish;
    logic             lat_ready;

    logic [CNT_W-1:0] idle_cycles;
    logic [CNT_W-1:0] active_cycles;
    logic [CNT_W-1:0] in_stall_cycles;
    logic [CNT_W-1:0] out_stall_cycles;
    logic [CNT_W-1:0] done_wait_cycles;
    logic [CNT_W-1:0] txn_count;
    logic             lat_valid;
    logic [CNT_W-1:0] lat_data;
    logic             lat_overflow;
    logic [1:0]       state;

    modport master (
        output clear, ap_start, ap_ready, ap_done, ap_continue,
               pin_stall, pout_stall, finish, lat_ready,
        input  idle_cycles, active_cycles, in_stall_cycles, out_stall_cycles,
               done_wait_cycles, txn_count, lat_valid, lat_data,
               lat_overflow, state
    );

    modport slave (
        input  clear, ap_start, ap_ready, ap_done, ap_continue,
               pin_stall, pout_stall, finish, lat_ready,
        output idle_cycles, active_cycles, in_stall_cycles, out_stall_cycles,
               done_wait_cycles, txn_count, lat_valid, lat_data,
               lat_overflow, state
    );
endinterface

// File: rtl/df_process_profiler.sv
// ----------------------------------------------------------------------------
// df_process_profiler
// Per-process dataflow profiler. Classifies every cycle of one HLS process
// (ap_ctrl_chain handshake plus FIFO stall flags) as idle / active /
// input-stall / output-stall / done-wait, keeps saturating cycle counters,
// and streams per-transaction latency records through a small FIFO.
//
// Ports
//   clock  : sampling clock, rising edge
//   reset  : asynchronous, active-low; clears all state
//   bus    : df_process_profiler_if.slave (handshake, controls, results)
// Parameters
//   CNT_W     : width of every counter and latency record
//   LAT_DEPTH : latency FIFO depth (power of two, >= 2)
// ----------------------------------------------------------------------------
module df_process_profiler #(
    parameter int CNT_W     = 32,
    parameter int LAT_DEPTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    df_process_profiler_if.slave bus
);
    localparam int PTR_W = $clog2(LAT_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(LAT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ACTIVE    = 2'd1,
        S_DONE_WAIT = 2'd2,
        S_FINISHED  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_idle, r_active, r_in_stall, r_out_stall, r_done_wait, r_txn;
    logic [CNT_W-1:0] r_mem [LAT_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_lat_valid;
    logic             r_overflow;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_lat_inc, w_lat_next, w_emit_lat;
    logic             w_emit;
    logic             w_inc_idle, w_inc_active, w_inc_in, w_inc_out, w_inc_dw;
    logic             w_pop, w_full, w_push, w_drop;
    logic [PTR_W:0]   w_count_next;

    // Cycle classification and next-state decode
    always_comb begin
        w_next_state = r_state;
        w_lat_inc    = sat_inc(r_lat);
        w_lat_next   = r_lat;
        w_emit       = 1'b0;
        w_emit_lat   = '0;
        w_inc_idle   = 1'b0;
        w_inc_active = 1'b0;
        w_inc_in     = 1'b0;
        w_inc_out    = 1'b0;
        w_inc_dw     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!bus.ap_start) begin
                    w_inc_idle = 1'b1;
                end else begin
                    w_inc_active = 1'b1;
                    w_lat_next   = CNT_W'(1);
                    if (bus.ap_done && bus.ap_continue) begin
                        w_emit     = 1'b1;
                        w_emit_lat = CNT_W'(1);
                    end else if (bus.ap_done) begin
                        w_next_state = S_DONE_WAIT;
                    end else begin
                        w_next_state = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                w_lat_next = w_lat_inc;
                if (bus.pin_stall)       w_inc_in     = 1'b1;
                else if (bus.pout_stall) w_inc_out    = 1'b1;
                else                     w_inc_active = 1'b1;
                if (bus.ap_done && bus.ap_continue) begin
                    w_emit       = 1'b1;
                    w_emit_lat   = w_lat_inc;
                    w_next_state = S_IDLE;
                end else if (bus.ap_done) begin
                    w_next_state = S_DONE_WAIT;
                end
            end
            S_DONE_WAIT: begin
                w_lat_next = w_lat_inc;
                w_inc_dw   = 1'b1;
                if (bus.ap_continue) begin
                    w_emit       = 1'b1;
                    w_emit_lat   = w_lat_inc;
                    w_next_state = S_IDLE;
                end
            end
            default: ;
        endcase
        // finish discards the cycle entirely: no count, no emit
        if (bus.finish) begin
            w_next_state = S_FINISHED;
            w_emit       = 1'b0;
            w_inc_idle   = 1'b0;
            w_inc_active = 1'b0;
            w_inc_in     = 1'b0;
            w_inc_out    = 1'b0;
            w_inc_dw     = 1'b0;
        end
    end

    // FIFO control; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        w_pop  = r_lat_valid && bus.lat_ready;
        w_full = (r_count == FULL_CNT);
        w_push = w_emit && (!w_full || w_pop);
        w_drop = w_emit && w_full && !w_pop;
        unique case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_lat       <= '0;
            r_idle      <= '0;
            r_active    <= '0;
            r_in_stall  <= '0;
            r_out_stall <= '0;
            r_done_wait <= '0;
            r_txn       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_lat_valid <= 1'b0;
            r_overflow  <= 1'b0;
            for (int unsigned i = 0; i < LAT_DEPTH; i++) r_mem[i] <= '0;
        end else if (bus.clear) begin
            r_state     <= S_IDLE;
            r_lat       <= '0;
            r_idle      <= '0;
            r_active    <= '0;
            r_in_stall  <= '0;
            r_out_stall <= '0;
            r_done_wait <= '0;
            r_txn       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_lat_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_lat   <= w_lat_next;
            if (w_inc_idle)   r_idle      <= sat_inc(r_idle);
            if (w_inc_active) r_active    <= sat_inc(r_active);
            if (w_inc_in)     r_in_stall  <= sat_inc(r_in_stall);
            if (w_inc_out)    r_out_stall <= sat_inc(r_out_stall);
            if (w_inc_dw)     r_done_wait <= sat_inc(r_done_wait);
            if (w_emit)       r_txn       <= sat_inc(r_txn);
            if (w_push) begin
                r_mem[r_wptr] <= w_emit_lat;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            r_count     <= w_count_next;
            r_lat_valid <= (w_count_next != '0);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign bus.idle_cycles      = r_idle;
    assign bus.active_cycles    = r_active;
    assign bus.in_stall_cycles  = r_in_stall;
    assign bus.out_stall_cycles = r_out_stall;
    assign bus.done_wait_cycles = r_done_wait;
    assign bus.txn_count        = r_txn;
    assign bus.lat_valid        = r_lat_valid;
    // Head is forced to zero while empty so stale slots never show
    assign bus.lat_data         = r_lat_valid ? r_mem[r_rptr] : '0;
    assign bus.lat_overflow     = r_overflow;
    assign bus.state            = r_state;
endmodule

// File: tb/tb_df_process_profiler.sv
// ----------------------------------------------------------------------------
// tb_df_process_profiler
// Directed bench for df_process_profiler. Latency records are checked by a
// scoreboard queue filled when completions are driven and drained by a
// monitor on every pop; counters and flags are checked directly. A second
// instance with 3-bit counters exercises saturation.
// ----------------------------------------------------------------------------
module tb_df_process_profiler;
    logic clock;
    logic reset;

    df_process_profiler_if #(.CNT_W(32)) bus ();
    df_process_profiler_if #(.CNT_W(3))  bus_s ();

    df_process_profiler #(.CNT_W(32), .LAT_DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    df_process_profiler #(.CNT_W(3), .LAT_DEPTH(8)) dut_s (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    assign bus_s.clear       = bus.clear;
    assign bus_s.ap_start    = bus.ap_start;
    assign bus_s.ap_ready    = bus.ap_ready;
    assign bus_s.ap_done     = bus.ap_done;
    assign bus_s.ap_continue = bus.ap_continue;
    assign bus_s.pin_stall   = bus.pin_stall;
    assign bus_s.pout_stall  = bus.pout_stall;
    assign bus_s.finish      = bus.finish;
    assign bus_s.lat_ready   = 1'b0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // v = {ap_start, ap_done, ap_continue, pin_stall, pout_stall}; one cycle
    task automatic cyc(input bit [4:0] v);
        bus.ap_start    = v[4];
        bus.ap_done     = v[3];
        bus.ap_continue = v[2];
        bus.pin_stall   = v[1];
        bus.pout_stall  = v[0];
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        cyc(5'b00000);
        bus.clear = 1'b1;
        @(posedge clock);
        #1;
        bus.clear = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        bus.clear       = 1'b0;
        bus.finish      = 1'b0;
        bus.ap_start    = 1'b0;
        bus.ap_ready    = 1'b0;
        bus.ap_done     = 1'b0;
        bus.ap_continue = 1'b0;
        bus.pin_stall   = 1'b0;
        bus.pout_stall  = 1'b0;
        bus.lat_ready   = 1'b1;

        fork
            forever begin
                @(negedge clock);
                if (reset && bus.lat_valid && bus.lat_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL lat_record: got %0d expected no record", bus.lat_data);
                    end else begin
                        logic [31:0] e;
                        e = exp_q.pop_front();
                        if (bus.lat_data !== e) begin
                            n_errors++;
                            $display("FAIL lat_record: got %0d expected %0d", bus.lat_data, e);
                        end
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values
        #12;
        chk("rst_idle",    bus.idle_cycles, 0);
        chk("rst_active",  bus.active_cycles, 0);
        chk("rst_in",      bus.in_stall_cycles, 0);
        chk("rst_out",     bus.out_stall_cycles, 0);
        chk("rst_dw",      bus.done_wait_cycles, 0);
        chk("rst_txn",     bus.txn_count, 0);
        chk("rst_valid",   32'(bus.lat_valid), 0);
        chk("rst_data",    bus.lat_data, 0);
        chk("rst_ovf",     32'(bus.lat_overflow), 0);
        chk("rst_state",   32'(bus.state), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Saturation on the 3-bit instance
        do_clear();
        repeat (10) cyc(5'b00000);
        chk("sat_idle_wide",  bus.idle_cycles, 10);
        chk("sat_idle_small", 32'(bus_s.idle_cycles), 7);
        do_clear();
        exp_q.push_back(10);
        cyc(5'b10000);
        repeat (8) cyc(5'b00000);
        cyc(5'b01100);
        chk("sat_lat_small",    32'(bus_s.lat_data), 7);
        chk("sat_active_small", 32'(bus_s.active_cycles), 7);
        chk("sat_txn_small",    32'(bus_s.txn_count), 1);

        // Basic transaction, latency 5
        do_clear();
        exp_q.push_back(5);
        cyc(5'b10000);
        repeat (3) cyc(5'b00000);
        cyc(5'b01100);
        chk("basic_active", bus.active_cycles, 5);
        chk("basic_txn",    bus.txn_count, 1);
        chk("basic_idle",   bus.idle_cycles, 0);
        chk("basic_valid",  32'(bus.lat_valid), 1);
        chk("basic_state",  32'(bus.state), 0);

        // Done-wait: done on cycle 4, continue on cycle 7
        do_clear();
        exp_q.push_back(7);
        cyc(5'b10000);
        repeat (2) cyc(5'b00000);
        cyc(5'b01000);
        chk("dw_state", 32'(bus.state), 2);
        repeat (2) cyc(5'b00000);
        cyc(5'b00100);
        chk("dw_cycles", bus.done_wait_cycles, 3);
        chk("dw_active", bus.active_cycles, 4);
        chk("dw_txn",    bus.txn_count, 1);

        // Stalls over a 10-cycle transaction
        do_clear();
        exp_q.push_back(10);
        cyc(5'b10000);
        cyc(5'b00000);
        cyc(5'b00010);
        cyc(5'b00010);
        cyc(5'b00011);
        cyc(5'b00001);
        repeat (3) cyc(5'b00000);
        cyc(5'b01100);
        chk("stall_in",     bus.in_stall_cycles, 3);
        chk("stall_out",    bus.out_stall_cycles, 1);
        chk("stall_active", bus.active_cycles, 6);

        // Same-cycle start+done+continue, back-to-back
        do_clear();
        repeat (4) exp_q.push_back(1);
        cyc(5'b11100);
        chk("b2b_state", 32'(bus.state), 0);
        repeat (3) cyc(5'b11100);
        chk("b2b_txn",    bus.txn_count, 4);
        chk("b2b_active", bus.active_cycles, 4);
        repeat (2) cyc(5'b00000);

        // Overflow: 9 records into an 8-deep FIFO, latencies 1..9
        do_clear();
        bus.lat_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) exp_q.push_back(32'(k));
            if (k == 1) begin
                cyc(5'b11100);
            end else begin
                cyc(5'b10000);
                repeat (k - 2) cyc(5'b00000);
                cyc(5'b01100);
            end
        end
        chk("ovf_flag", 32'(bus.lat_overflow), 1);
        chk("ovf_head", bus.lat_data, 1);
        chk("ovf_txn",  bus.txn_count, 9);
        // Completion of a 10-cycle txn coincides with a pop while full
        cyc(5'b10000);
        repeat (8) cyc(5'b00000);
        exp_q.push_back(10);
        bus.lat_ready = 1'b1;
        cyc(5'b01100);
        bus.lat_ready = 1'b0;
        chk("fullpop_head",  bus.lat_data, 2);
        chk("fullpop_valid", 32'(bus.lat_valid), 1);
        chk("fullpop_ovf",   32'(bus.lat_overflow), 1);
        bus.lat_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(5'b00000);
        chk("drain_queue", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(bus.lat_valid), 0);
        do_clear();
        chk("clr_ovf",    32'(bus.lat_overflow), 0);
        chk("clr_txn",    bus.txn_count, 0);
        chk("clr_active", bus.active_cycles, 0);
        chk("clr_idle",   bus.idle_cycles, 0);
        chk("clr_state",  32'(bus.state), 0);

        // finish mid-transaction at cycle 3
        do_clear();
        cyc(5'b10000);
        cyc(5'b00000);
        bus.finish = 1'b1;
        cyc(5'b00010);
        bus.finish = 1'b0;
        chk("fin_state",  32'(bus.state), 3);
        chk("fin_active", bus.active_cycles, 2);
        chk("fin_in",     bus.in_stall_cycles, 0);
        repeat (20) cyc(5'b11110);
        chk("frz_active", bus.active_cycles, 2);
        chk("frz_idle",   bus.idle_cycles, 0);
        chk("frz_txn",    bus.txn_count, 0);
        chk("frz_valid",  32'(bus.lat_valid), 0);
        chk("frz_state",  32'(bus.state), 3);

        // Asynchronous reset mid-transaction
        do_clear();
        bus.lat_ready = 1'b0;
        cyc(5'b10000);
        cyc(5'b00000);
        cyc(5'b01100);
        cyc(5'b10000);
        cyc(5'b00000);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_active", bus.active_cycles, 0);
        chk("arst_txn",    bus.txn_count, 0);
        chk("arst_valid",  32'(bus.lat_valid), 0);
        chk("arst_data",   bus.lat_data, 0);
        chk("arst_state",  32'(bus.state), 0);
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.lat_ready = 1'b1;
        cyc(5'b00000);
        chk("post_rst_idle",  bus.idle_cycles, 1);
        chk("post_rst_state", 32'(bus.state), 0);

        repeat (2) cyc(5'b00000);
        chk("final_queue", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
